// File: rtl/add_mul_mix_pkg.sv
// Shared types, default widths and helpers for the add/mul mix accumulator stage.
package add_mul_mix_pkg;

    localparam int unsigned RES_W = 8;
    localparam int unsigned ACC_W = 11;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Block length field of zero means the largest block, 2^cnt_w beats.
    function automatic logic [31:0] len_decode(input logic [31:0] len, input int unsigned cnt_w);
        return (len == 32'd0) ? (32'd1 << cnt_w) : len;
    endfunction

endpackage

// File: rtl/add_mul_mix_sat_add.sv
// Unsigned saturating adder: accumulator plus one result, clamps to all-ones on carry out.
module add_mul_mix_sat_add #(
    parameter int unsigned ACC_W = 11,
    parameter int unsigned RES_W = 8
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [RES_W-1:0] i_val,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W:0] w_full;

    assign w_full = {1'b0, i_acc} + (ACC_W+1)'(i_val);
    assign o_ovf  = w_full[ACC_W];
    assign o_sum  = o_ovf ? '1 : w_full[ACC_W-1:0];

endmodule

// File: rtl/add_mul_mix_accum.sv
// Accumulates a programmable block of mixer results and presents one saturated block sum
// over a valid/ready handshake.
module add_mul_mix_accum #(
    parameter int unsigned RES_W = add_mul_mix_pkg::RES_W,
    parameter int unsigned ACC_W = add_mul_mix_pkg::ACC_W,
    parameter int unsigned CNT_W = add_mul_mix_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_result,
    input  logic [CNT_W-1:0] block_len,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W:0]   out_count,
    output logic             out_sat,
    output logic             busy
);

    import add_mul_mix_pkg::*;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W:0]   r_len;
    logic [CNT_W:0]   r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W:0]   r_out_count;
    logic             r_out_sat;

    logic             w_beat;
    logic             w_take;
    logic [CNT_W:0]   w_len;
    logic [CNT_W:0]   w_cnt_inc;
    logic [ACC_W-1:0] w_sum;
    logic             w_ovf;
    logic             w_load;
    logic             w_add;
    logic             w_cap;
    logic [ACC_W-1:0] w_nxt_acc;
    logic [CNT_W:0]   w_nxt_cnt;
    logic             w_nxt_sat;

    assign w_beat    = in_valid & r_in_ready;
    assign w_take    = r_out_valid & out_ready;
    assign w_len     = (CNT_W+1)'(len_decode(32'(block_len), CNT_W));
    assign w_cnt_inc = r_cnt + (CNT_W+1)'(1);

    add_mul_mix_sat_add #(
        .ACC_W (ACC_W),
        .RES_W (RES_W)
    ) u_sat_add (
        .i_acc (r_acc),
        .i_val (in_result),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    w_state_nxt = (w_len == (CNT_W+1)'(1) || flush) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if ((w_beat && w_cnt_inc == r_len) || flush) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_take) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath strobes and the block values that become current after this cycle.
    always_comb begin
        w_load    = 1'b0;
        w_add     = 1'b0;
        w_cap     = 1'b0;
        w_nxt_acc = r_acc;
        w_nxt_cnt = r_cnt;
        w_nxt_sat = r_sat;
        if (r_state == IDLE && w_beat) begin
            w_load    = 1'b1;
            w_nxt_acc = ACC_W'(in_result);
            w_nxt_cnt = (CNT_W+1)'(1);
            w_nxt_sat = 1'b0;
        end else if (r_state == ACCUM && w_beat) begin
            w_add     = 1'b1;
            w_nxt_acc = w_sum;
            w_nxt_cnt = w_cnt_inc;
            w_nxt_sat = r_sat | w_ovf;
        end
        w_cap = (r_state != HOLD) && (w_state_nxt == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_load) begin
                r_len <= w_len;
            end
            if (w_load || w_add) begin
                r_acc <= w_nxt_acc;
                r_cnt <= w_nxt_cnt;
                r_sat <= w_nxt_sat;
            end
            if (w_cap) begin
                r_out_sum   <= w_nxt_acc;
                r_out_count <= w_nxt_cnt;
                r_out_sat   <= w_nxt_sat;
            end
            // State-decoded outputs are registered from the next state so they track r_state.
            r_out_valid <= (w_state_nxt == HOLD);
            r_in_ready  <= (w_state_nxt != HOLD);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;
    assign busy      = r_busy;

endmodule
